// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  localparam int unsigned FLUSH_CNT_W = 4;
  localparam int unsigned X0          = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/exec/writeback control bundle; master = pipeline side, slave = controller.
// Forwarding selects exist only when PIPE_HAZARD_FWD_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  import pipe_hazard_ctrl_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_writes_rd;
  logic                  id_issue;
  logic                  if_stall;
  logic                  id_flush;
  logic                  ex_bubble;
  logic                  ex_valid;
  logic                  ex_redirect;
  logic [XLEN-1:0]       ex_target;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  pc_redirect_valid;
  logic [XLEN-1:0]       pc_redirect_addr;
`ifdef PIPE_HAZARD_FWD_EN
  fwd_sel_e              fwd_rs1_sel;
  fwd_sel_e              fwd_rs2_sel;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_writes_rd,
    output ex_valid, ex_redirect, ex_target, wb_valid, wb_rd,
    input  id_issue, if_stall, id_flush, ex_bubble, pc_redirect_valid, pc_redirect_addr
`ifdef PIPE_HAZARD_FWD_EN
    , input fwd_rs1_sel, fwd_rs2_sel
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_writes_rd,
    input  ex_valid, ex_redirect, ex_target, wb_valid, wb_rd,
    output id_issue, if_stall, id_flush, ex_bubble, pc_redirect_valid, pc_redirect_addr
`ifdef PIPE_HAZARD_FWD_EN
    , output fwd_rs1_sel, fwd_rs2_sel
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// One busy bit per architectural register; x0 never marked busy.
module pipe_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] rd_a_idx,
  output logic                  rd_a_hit,
  input  logic [REG_ADDR_W-1:0] rd_b_idx,
  output logic                  rd_b_hit
);

  localparam int unsigned NREGS = 1 << REG_ADDR_W;

  logic [NREGS-1:0] sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (clr_en) sb[clr_idx] <= 1'b0;
      // Later assignment wins, so a same-index set overrides the clear.
      if (set_en && set_idx != REG_ADDR_W'(X0)) sb[set_idx] <= 1'b1;
    end
  end

  assign rd_a_hit = sb[rd_a_idx];
  assign rd_b_hit = sb[rd_b_idx];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 4-stage core: RAW stalls and timed redirect flush.
// Define PIPE_HAZARD_FWD_EN to add exec/wb forwarding selects and suppress forwardable stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  hazard_state_e          state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   redir_pulse_q;
  logic [XLEN-1:0]        redir_addr_q;

  logic rs1_busy, rs2_busy, rs1_block, rs2_block;
  logic hazard, redirect_now, issue, stall, flush, bubble;

  pipe_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue & bus.id_writes_rd),
    .set_idx  (bus.id_rd),
    .clr_en   (bus.wb_valid),
    .clr_idx  (bus.wb_rd),
    .rd_a_idx (bus.id_rs1),
    .rd_a_hit (rs1_busy),
    .rd_b_idx (bus.id_rs2),
    .rd_b_hit (rs2_busy)
  );

`ifdef PIPE_HAZARD_FWD_EN
  logic                  ex_rd_valid_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  fwd_sel_e              sel1, sel2;

  function automatic fwd_sel_e fwd_pick(input logic [REG_ADDR_W-1:0] src,
                                        input logic ex_v, input logic [REG_ADDR_W-1:0] ex_rd,
                                        input logic wb_v, input logic [REG_ADDR_W-1:0] wb_rd);
    if (src == REG_ADDR_W'(X0))      return FWD_RF;
    else if (ex_v && ex_rd == src)   return FWD_EX;
    else if (wb_v && wb_rd == src)   return FWD_WB;
    else                             return FWD_RF;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd_valid_q <= 1'b0;
      ex_rd_q       <= '0;
    end else begin
      ex_rd_valid_q <= issue & bus.id_writes_rd & (bus.id_rd != REG_ADDR_W'(X0));
      ex_rd_q       <= bus.id_rd;
    end
  end

  always_comb begin
    sel1 = fwd_pick(bus.id_rs1, ex_rd_valid_q, ex_rd_q, bus.wb_valid, bus.wb_rd);
    sel2 = fwd_pick(bus.id_rs2, ex_rd_valid_q, ex_rd_q, bus.wb_valid, bus.wb_rd);
    rs1_block = bus.id_uses_rs1 & rs1_busy & (sel1 == FWD_RF);
    rs2_block = bus.id_uses_rs2 & rs2_busy & (sel2 == FWD_RF);
  end

  assign bus.fwd_rs1_sel = rst ? FWD_RF : sel1;
  assign bus.fwd_rs2_sel = rst ? FWD_RF : sel2;
`else
  assign rs1_block = bus.id_uses_rs1 & rs1_busy;
  assign rs2_block = bus.id_uses_rs2 & rs2_busy;
`endif

  // Redirect outranks a same-cycle hazard: the decode instruction is flushed, not stalled.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hazard       = 1'b0;
    redirect_now = 1'b0;
    issue        = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    bubble       = 1'b0;
    case (state_q)
      RUN: begin
        redirect_now = bus.ex_valid & bus.ex_redirect;
        hazard       = bus.id_valid & (rs1_block | rs2_block);
        issue        = bus.id_valid & ~hazard & ~redirect_now;
        stall        = hazard & ~redirect_now;
        bubble       = hazard | redirect_now;
        flush        = redirect_now;
        if (redirect_now) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      redirect_now = 1'b0;
      issue        = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
      bubble       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      redir_pulse_q <= 1'b0;
      redir_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_pulse_q <= redirect_now;
      if (redirect_now) redir_addr_q <= bus.ex_target;
    end
  end

  assign bus.id_issue          = issue;
  assign bus.if_stall          = stall;
  assign bus.id_flush          = flush;
  assign bus.ex_bubble         = bubble;
  assign bus.pc_redirect_valid = redir_pulse_q & ~rst;
  assign bus.pc_redirect_addr  = rst ? '0 : redir_addr_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random stimulus for pipe_hazard_ctrl, checked against a busy-set / flush-countdown model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int          FC   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus();

  pipe_hazard_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RW), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: set of pending writers, flush cycles still owed, pending fetch redirect.
  bit          busy [32];
  int          flush_left = 0;
  bit          pulse_m    = 1'b0;
  logic [31:0] addr_m     = '0;
  int          ex_rd_m    = -1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fwd_of(input int s);
    if (s == 0) return 0;
    if (ex_rd_m == s) return 1;
    if (bus.wb_valid && int'(bus.wb_rd) == s) return 2;
    return 0;
  endfunction

  function automatic bit blocks(input int s, input bit uses);
`ifdef PIPE_HAZARD_FWD_EN
    return uses && busy[s] && fwd_of(s) == 0;
`else
    return uses && busy[s];
`endif
  endfunction

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.id_rd = '0; bus.id_writes_rd = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0;
  endtask

  // Inputs are already applied; check mid-cycle, advance the model, move past the next edge.
  task automatic cycle(input string tag);
    bit redir, haz, iss, stl, fl, bub;
    int s1, s2, rd;
    #4;
    s1 = int'(bus.id_rs1); s2 = int'(bus.id_rs2); rd = int'(bus.id_rd);
    redir = 0; haz = 0; iss = 0; stl = 0; fl = 0; bub = 0;
    if (!rst) begin
      if (flush_left > 0) begin
        fl = 1; bub = 1;
      end else begin
        redir = bus.ex_valid && bus.ex_redirect;
        haz   = bus.id_valid && (blocks(s1, bus.id_uses_rs1) || blocks(s2, bus.id_uses_rs2));
        iss   = bus.id_valid && !haz && !redir;
        stl   = haz && !redir;
        bub   = haz || redir;
        fl    = redir;
      end
    end
    chk({tag, ".issue"},  32'(bus.id_issue),  32'(iss));
    chk({tag, ".stall"},  32'(bus.if_stall),  32'(stl));
    chk({tag, ".flush"},  32'(bus.id_flush),  32'(fl));
    chk({tag, ".bubble"}, 32'(bus.ex_bubble), 32'(bub));
    chk({tag, ".pcv"},    32'(bus.pc_redirect_valid), rst ? 32'd0 : 32'(pulse_m));
    chk({tag, ".pca"},    bus.pc_redirect_addr, rst ? 32'd0 : addr_m);
`ifdef PIPE_HAZARD_FWD_EN
    chk({tag, ".fwd1"}, 32'(bus.fwd_rs1_sel), rst ? 32'd0 : 32'(fwd_of(s1)));
    chk({tag, ".fwd2"}, 32'(bus.fwd_rs2_sel), rst ? 32'd0 : 32'(fwd_of(s2)));
`endif
    if (rst) begin
      foreach (busy[i]) busy[i] = 1'b0;
      flush_left = 0; pulse_m = 1'b0; addr_m = '0; ex_rd_m = -1;
    end else begin
      if (bus.wb_valid) busy[int'(bus.wb_rd)] = 1'b0;
      if (iss && bus.id_writes_rd && rd != 0) busy[rd] = 1'b1;
      ex_rd_m = (iss && bus.id_writes_rd && rd != 0) ? rd : -1;
      pulse_m = redir;
      if (redir) addr_m = bus.ex_target;
      if (flush_left > 0) flush_left--;
      else if (redir) flush_left = FC;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (busy[i]) busy[i] = 1'b0;
    idle();
    rst = 1'b1;
    bus.id_valid = 1'b1; bus.id_rd = 5'd9; bus.id_writes_rd = 1'b1;
    @(posedge clk); #1;
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;

    // RAW on x5, released one cycle after its writeback
    idle(); bus.id_valid = 1'b1; bus.id_rd = 5'd5; bus.id_writes_rd = 1'b1;
    cycle("raw_wr");
    idle(); bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    cycle("raw_stall");
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    cycle("raw_wb");
    bus.wb_valid = 1'b0;
    cycle("raw_go");

    // Redirect; a second redirect during FLUSH must be ignored
    idle(); bus.id_valid = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h0000_0100;
    cycle("redir");
    bus.ex_target = 32'h0000_0200;
    cycle("flush1");
    bus.ex_redirect = 1'b0;
    cycle("flush2");
    cycle("post_flush");

    // x0 never busy
    idle(); bus.id_valid = 1'b1; bus.id_rd = 5'd0; bus.id_writes_rd = 1'b1;
    cycle("x0_wr");
    idle(); bus.id_valid = 1'b1; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
    bus.id_rs2 = 5'd0; bus.id_uses_rs2 = 1'b1;
    cycle("x0_rd");

    // Same-cycle set and clear of x7: set wins
    idle(); bus.id_valid = 1'b1; bus.id_rd = 5'd7; bus.id_writes_rd = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    cycle("setwin_wr");
    idle(); cycle("setwin_gap");
    bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    cycle("setwin_rd");
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    cycle("setwin_clr");
    bus.wb_valid = 1'b0;
    cycle("setwin_go");

    // Reset in the first FLUSH cycle aborts the sequence
    idle(); bus.ex_valid = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h0000_0340;
    cycle("mrst_redir");
    idle(); rst = 1'b1;
    cycle("mrst_rst");
    rst = 1'b0;
    cycle("mrst_after");
    cycle("mrst_after2");

    // Back-to-back writer x3 / readers of x3
    idle(); bus.id_valid = 1'b1; bus.id_rd = 5'd3; bus.id_writes_rd = 1'b1;
    cycle("fwd_wr");
    idle(); bus.id_valid = 1'b1; bus.id_rs2 = 5'd3; bus.id_uses_rs2 = 1'b1;
    bus.id_rd = 5'd4; bus.id_writes_rd = 1'b1;
    cycle("fwd_ex");
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
    cycle("fwd_wb");
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd4;
    cycle("fwd_drain");
    idle();

    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      bus.id_valid     = ($urandom_range(0, 3) != 0);
      bus.id_rs1       = RW'($urandom_range(0, 7));
      bus.id_rs2       = RW'($urandom_range(0, 7));
      bus.id_uses_rs1  = $urandom_range(0, 1) == 1;
      bus.id_uses_rs2  = $urandom_range(0, 1) == 1;
      bus.id_rd        = RW'($urandom_range(0, 7));
      bus.id_writes_rd = $urandom_range(0, 1) == 1;
      bus.ex_valid     = ($urandom_range(0, 3) != 0);
      bus.ex_redirect  = ($urandom_range(0, 9) == 0);
      bus.ex_target    = $urandom();
      bus.wb_valid     = ($urandom_range(0, 9) < 4);
      bus.wb_rd        = RW'($urandom_range(0, 7));
      cycle("rnd");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
